// File: rtl/writeback_regfile_unit.sv
// rtl/writeback_regfile_unit.sv - LC3 writeback stage with register file, PSR and bypassed read ports
module writeback_regfile_unit #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 8,
  parameter int AW         = $clog2(NUM_REGS),
  parameter int CC_ON_LINK = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [1:0]        w_control_in,
  input  logic              enable_writeback,
  input  logic [AW-1:0]     sr1,
  input  logic [AW-1:0]     sr2,
  input  logic [AW-1:0]     dr,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [2:0]        psr,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [AW-1:0]     wb_dr,
  output logic [CNT_W-1:0]  commit_cnt
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_d2;
  logic [2:0]        r_psr;
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [AW-1:0]     r_wb_dr;
  logic [CNT_W-1:0]  r_commit_cnt;

  logic [DATA_W-1:0] w_wdata;
  logic              w_n;
  logic              w_z;
  logic              w_cc_upd;
  logic              w_byp1;
  logic              w_byp2;

  // Writeback source mux: 0 alu, 1 mem, 2 pc (LEA), 3 npc (link)
  always_comb begin
    w_wdata = aluout;
    case (w_control_in)
      2'd0: w_wdata = aluout;
      2'd1: w_wdata = memout;
      2'd2: w_wdata = pcout;
      2'd3: w_wdata = npc;
      default: w_wdata = aluout;
    endcase
  end

  assign w_n      = w_wdata[DATA_W-1];
  assign w_z      = (w_wdata == '0);
  // A link write leaves the condition codes alone unless the core is built to update them
  assign w_cc_upd = enable_writeback && ((w_control_in != 2'd3) || (CC_ON_LINK != 0));
  // Forward the value being committed so a same-cycle read never returns the stale entry
  assign w_byp1   = enable_writeback && (dr == sr1);
  assign w_byp2   = enable_writeback && (dr == sr2);

  // Architectural register file commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (enable_writeback) begin
      r_regs[dr] <= w_wdata;
    end
  end

  // Registered source-operand reads with write-through bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      r_d1 <= w_byp1 ? w_wdata : r_regs[sr1];
      r_d2 <= w_byp2 ? w_wdata : r_regs[sr2];
    end
  end

  // Condition codes {N,Z,P}; exactly one bit set after any qualifying commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psr <= 3'b000;
    end else if (w_cc_upd) begin
      r_psr <= {w_n, w_z, (!w_n && !w_z)};
    end
  end

  // Commit status: valid pulse, last committed value/destination, wrapping commit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_dr      <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_wb_valid <= enable_writeback;
      if (enable_writeback) begin
        r_wb_data    <= w_wdata;
        r_wb_dr      <= dr;
        r_commit_cnt <= r_commit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign d1         = r_d1;
  assign d2         = r_d2;
  assign psr        = r_psr;
  assign wb_valid   = r_wb_valid;
  assign wb_data    = r_wb_data;
  assign wb_dr      = r_wb_dr;
  assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_writeback_regfile_unit.sv
// tb/tb_writeback_regfile_unit.sv - directed table-driven bench for writeback_regfile_unit
module tb_writeback_regfile_unit;

  logic        clk;
  logic        rst;
  logic [15:0] npc, aluout, pcout, memout;
  logic [1:0]  wc;
  logic        en;
  logic [2:0]  sr1, sr2, dr;

  logic [15:0] d1_a, d2_a, wbd_a;
  logic [2:0]  psr_a, wbdr_a;
  logic        wbv_a;
  logic [15:0] cnt_a;

  logic [15:0] d1_b, d2_b, wbd_b;
  logic [2:0]  psr_b, wbdr_b;
  logic        wbv_b;
  logic [3:0]  cnt_b;

  logic [31:0] npc_c, alu_c, pc_c, mem_c;
  logic [1:0]  wc_c;
  logic        en_c;
  logic [3:0]  sr1_c, sr2_c, dr_c;
  logic [31:0] d1_c, d2_c, wbd_c;
  logic [2:0]  psr_c;
  logic        wbv_c;
  logic [3:0]  wbdr_c;
  logic [15:0] cnt_c;

  int n_total = 0;
  int n_pass  = 0;

  writeback_regfile_unit dut_a (
    .clk(clk), .rst(rst), .npc(npc), .aluout(aluout), .pcout(pcout), .memout(memout),
    .w_control_in(wc), .enable_writeback(en), .sr1(sr1), .sr2(sr2), .dr(dr),
    .d1(d1_a), .d2(d2_a), .psr(psr_a), .wb_valid(wbv_a), .wb_data(wbd_a),
    .wb_dr(wbdr_a), .commit_cnt(cnt_a)
  );

  writeback_regfile_unit #(.CC_ON_LINK(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .npc(npc), .aluout(aluout), .pcout(pcout), .memout(memout),
    .w_control_in(wc), .enable_writeback(en), .sr1(sr1), .sr2(sr2), .dr(dr),
    .d1(d1_b), .d2(d2_b), .psr(psr_b), .wb_valid(wbv_b), .wb_data(wbd_b),
    .wb_dr(wbdr_b), .commit_cnt(cnt_b)
  );

  writeback_regfile_unit #(.DATA_W(32), .NUM_REGS(16)) dut_c (
    .clk(clk), .rst(rst), .npc(npc_c), .aluout(alu_c), .pcout(pc_c), .memout(mem_c),
    .w_control_in(wc_c), .enable_writeback(en_c), .sr1(sr1_c), .sr2(sr2_c), .dr(dr_c),
    .d1(d1_c), .d2(d2_c), .psr(psr_c), .wb_valid(wbv_c), .wb_data(wbd_c),
    .wb_dr(wbdr_c), .commit_cnt(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  wc;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] alu;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  psr_a;
    logic [2:0]  psr_b;
    logic        wbv;
    logic [15:0] wbd;
    logic [2:0]  wbdr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Source select, link CC hold/update, bypass, no-write bypass, back-to-back same dr
    tbl[0] = '{1'b1, 2'd0, 3'd3, 3'd3, 3'd0, 16'h0011, 16'h0011, 16'h0000, 3'b001, 3'b001, 1'b1, 16'h0011, 3'd3, 16'd1};
    tbl[1] = '{1'b1, 2'd1, 3'd3, 3'd3, 3'd3, 16'h0011, 16'h8000, 16'h8000, 3'b100, 3'b100, 1'b1, 16'h8000, 3'd3, 16'd2};
    tbl[2] = '{1'b1, 2'd2, 3'd3, 3'd3, 3'd3, 16'h0011, 16'h0000, 16'h0000, 3'b010, 3'b010, 1'b1, 16'h0000, 3'd3, 16'd3};
    tbl[3] = '{1'b1, 2'd3, 3'd3, 3'd3, 3'd3, 16'h0011, 16'h3001, 16'h3001, 3'b010, 3'b001, 1'b1, 16'h3001, 3'd3, 16'd4};
    tbl[4] = '{1'b0, 2'd0, 3'd3, 3'd3, 3'd5, 16'h0011, 16'h3001, 16'h0000, 3'b010, 3'b001, 1'b0, 16'h3001, 3'd3, 16'd4};
    tbl[5] = '{1'b1, 2'd0, 3'd5, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 3'b100, 3'b100, 1'b1, 16'hBEEF, 3'd5, 16'd5};
    tbl[6] = '{1'b0, 2'd0, 3'd5, 3'd5, 3'd5, 16'h1111, 16'hBEEF, 16'hBEEF, 3'b100, 3'b100, 1'b0, 16'hBEEF, 3'd5, 16'd5};
    tbl[7] = '{1'b1, 2'd0, 3'd2, 3'd0, 3'd3, 16'h1234, 16'h0000, 16'h3001, 3'b001, 3'b001, 1'b1, 16'h1234, 3'd2, 16'd6};
    tbl[8] = '{1'b1, 2'd0, 3'd2, 3'd4, 3'd2, 16'h5678, 16'h0000, 16'h5678, 3'b001, 3'b001, 1'b1, 16'h5678, 3'd2, 16'd7};
    tbl[9] = '{1'b0, 2'd0, 3'd2, 3'd2, 3'd6, 16'h9999, 16'h5678, 16'h0000, 3'b001, 3'b001, 1'b0, 16'h5678, 3'd2, 16'd7};

    memout = 16'h8000; pcout = 16'h0000; npc = 16'h3001;
    aluout = 16'h0000; wc = 2'd0; en = 1'b0; sr1 = '0; sr2 = '0; dr = '0;
    npc_c = '0; alu_c = '0; pc_c = '0; mem_c = '0; wc_c = '0; en_c = 1'b0;
    sr1_c = '0; sr2_c = '0; dr_c = '0;

    // Reset held with active commit traffic
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'b1; en_c = 1'b1; wc = i[1:0]; dr = i[2:0]; sr1 = i[2:0]; sr2 = i[2:0];
      aluout = 16'hA5A5 ^ i[15:0]; alu_c = 32'hDEAD_0000 | i;
    end
    @(negedge clk);
    chk("rst_d1", {16'h0, d1_a}, 32'h0);
    chk("rst_d2", {16'h0, d2_a}, 32'h0);
    chk("rst_psr", {29'h0, psr_a}, 32'h0);
    chk("rst_cnt", {16'h0, cnt_a}, 32'h0);
    chk("rst_wbv", {31'h0, wbv_a}, 32'h0);
    chk("rst_c_d1", d1_c, 32'h0);
    en = 1'b0; en_c = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      sr1 = 3'(2 * i); sr2 = 3'(2 * i + 1);
      step();
      chk($sformatf("rst_r%0d", 2 * i), {16'h0, d1_a}, 32'h0);
      chk($sformatf("rst_r%0d", 2 * i + 1), {16'h0, d2_a}, 32'h0);
    end
    chk("rst_cnt_after", {16'h0, cnt_a}, 32'h0);

    // Table vectors
    for (int v = 0; v < 10; v++) begin
      en = tbl[v].en; wc = tbl[v].wc; dr = tbl[v].dr;
      sr1 = tbl[v].sr1; sr2 = tbl[v].sr2; aluout = tbl[v].alu;
      step();
      chk($sformatf("v%0d_d1", v), {16'h0, d1_a}, {16'h0, tbl[v].d1});
      chk($sformatf("v%0d_d2", v), {16'h0, d2_a}, {16'h0, tbl[v].d2});
      chk($sformatf("v%0d_psr", v), {29'h0, psr_a}, {29'h0, tbl[v].psr_a});
      chk($sformatf("v%0d_psr_link", v), {29'h0, psr_b}, {29'h0, tbl[v].psr_b});
      chk($sformatf("v%0d_wbv", v), {31'h0, wbv_a}, {31'h0, tbl[v].wbv});
      chk($sformatf("v%0d_wbd", v), {16'h0, wbd_a}, {16'h0, tbl[v].wbd});
      chk($sformatf("v%0d_wbdr", v), {29'h0, wbdr_a}, {29'h0, tbl[v].wbdr});
      chk($sformatf("v%0d_cnt", v), {16'h0, cnt_a}, {16'h0, tbl[v].cnt});
      chk($sformatf("v%0d_cnt4", v), {28'h0, cnt_b}, {28'h0, tbl[v].cnt[3:0]});
    end

    // Counter wrap: 17 commits from reset
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      en = 1'b1; wc = 2'd0; dr = 3'd1; aluout = 16'(i + 1);
      step();
    end
    en = 1'b0;
    chk("wrap_cnt4", {28'h0, cnt_b}, 32'd1);
    chk("wrap_cnt16", {16'h0, cnt_a}, 32'd17);

    // Asynchronous reset during a commit stream
    en = 1'b1; dr = 3'd4; aluout = 16'hAAAA;
    step();
    chk("pre_rst_wbd", {16'h0, wbd_a}, 32'h0000AAAA);
    aluout = 16'h5555; sr1 = 3'd4;
    #2 rst = 1'b0;
    #1;
    chk("async_wbv", {31'h0, wbv_a}, 32'h0);
    chk("async_wbd", {16'h0, wbd_a}, 32'h0);
    chk("async_cnt", {16'h0, cnt_a}, 32'h0);
    chk("async_psr", {29'h0, psr_a}, 32'h0);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sr1 = 3'd4;
    step();
    chk("async_r4_absent", {16'h0, d1_a}, 32'h0);
    en = 1'b1; dr = 3'd6; aluout = 16'h0042; sr1 = 3'd6;
    step();
    en = 1'b0;
    chk("post_rst_d1", {16'h0, d1_a}, 32'h00000042);
    chk("post_rst_wbv", {31'h0, wbv_a}, 32'h1);
    chk("post_rst_cnt", {16'h0, cnt_a}, 32'h1);

    // 32-bit, 16-register instance: bypass and N on bit 31
    en_c = 1'b1; wc_c = 2'd0; alu_c = 32'h8000_0001; dr_c = 4'd13; sr1_c = 4'd13; sr2_c = 4'd13;
    step();
    chk("c1_d1", d1_c, 32'h8000_0001);
    chk("c1_d2", d2_c, 32'h8000_0001);
    chk("c1_psr", {29'h0, psr_c}, 32'b100);
    chk("c1_wbdr", {28'h0, wbdr_c}, 32'd13);
    wc_c = 2'd1; mem_c = 32'h0; dr_c = 4'd15; sr1_c = 4'd13; sr2_c = 4'd15;
    step();
    chk("c2_d1", d1_c, 32'h8000_0001);
    chk("c2_d2", d2_c, 32'h0);
    chk("c2_psr", {29'h0, psr_c}, 32'b010);
    wc_c = 2'd3; npc_c = 32'h7FFF_0000; dr_c = 4'd9; sr1_c = 4'd9; sr2_c = 4'd15;
    step();
    chk("c3_d1", d1_c, 32'h7FFF_0000);
    chk("c3_psr", {29'h0, psr_c}, 32'b010);
    chk("c3_cnt", {16'h0, cnt_c}, 32'd3);
    wc_c = 2'd2; pc_c = 32'h0000_0005; dr_c = 4'd9; sr1_c = 4'd9; sr2_c = 4'd9;
    step();
    chk("c4_d1", d1_c, 32'h5);
    chk("c4_d2", d2_c, 32'h5);
    chk("c4_psr", {29'h0, psr_c}, 32'b001);
    en_c = 1'b0; wc_c = 2'd0; alu_c = 32'hFFFF_FFFF; sr1_c = 4'd9; sr2_c = 4'd13;
    step();
    chk("c5_d1", d1_c, 32'h5);
    chk("c5_d2", d2_c, 32'h8000_0001);
    chk("c5_psr", {29'h0, psr_c}, 32'b001);
    chk("c5_wbv", {31'h0, wbv_c}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/writeback_regfile_unit.md
Name: writeback_regfile_unit

Overview:
- Parametrised writeback stage plus architectural register file for the LC3 core.
- Selects the writeback data from the four result buses (npc/aluout/pcout/memout) and commits it to the register file.
- Updates the condition-code register (PSR N/Z/P) and serves two registered source-operand reads with write-through bypass.
- Sits between the execute/memaccess stages and decode; it is the DUT behind the writeback_in agent, generalised in data width, register count and link-write condition-code mode.

Parameters:
- DATA_W, 16, width of all data buses and registers.
- NUM_REGS, 8, number of architectural registers; power of 2, >=2.
- AW, $clog2(NUM_REGS), register address width (derived; do not override).
- CC_ON_LINK, 0, 1 = a w_control_in==3 (npc link) write also updates PSR.
- CNT_W, 16, width of the commit counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- npc  input  DATA_W  next-PC value (link source).
- aluout  input  DATA_W  execute result.
- pcout  input  DATA_W  computed address (LEA).
- memout  input  DATA_W  load data.
- w_control_in  input  2  writeback source select.
- enable_writeback  input  1  commit strobe.
- sr1  input  AW  source register 1 address.
- sr2  input  AW  source register 2 address.
- dr  input  AW  destination register address.
- d1  output  DATA_W  registered read of sr1.
- d2  output  DATA_W  registered read of sr2.
- psr  output  3  condition codes {N,Z,P}.
- wb_valid  output  1  pulses the cycle after a commit.
- wb_data  output  DATA_W  value committed, held until next commit.
- wb_dr  output  AW  register written by the last commit.
- commit_cnt  output  CNT_W  number of commits since reset.

Behaviour:
- Single clock domain. rst low asynchronously clears all state; release is synchronous to clk.
- Reset values: all registers 0, d1=0, d2=0, psr=3'b000, wb_valid=0, wb_data=0, wb_dr=0, commit_cnt=0.
- Source mux (combinational): wdata = w_control_in 0:aluout, 1:memout, 2:pcout, 3:npc.
- Commit: at a rising edge with enable_writeback=1, R[dr] <= wdata. No write when enable_writeback=0; the inputs are don't-care in that case.
- PSR:
  - Updated on the same edge as a commit, unless w_control_in==3 and CC_ON_LINK==0 (psr then holds).
  - N = wdata[DATA_W-1]; Z = (wdata==0); P = !N && !Z. Exactly one bit is set after the first qualifying commit.
- Read ports:
  - d1/d2 are updated every edge (1-cycle latency) from the sr1/sr2 sampled at that edge.
  - Bypass: if enable_writeback && dr==srX on that edge, dX <= wdata (new value), never the stale R[srX].
  - sr1==sr2 returns the same value on both ports.
- Status:
  - wb_valid <= enable_writeback (a 1-cycle pulse per commit).
  - On a commit, wb_data <= wdata and wb_dr <= dr; otherwise both hold.
  - commit_cnt increments by 1 per commit and wraps from 2^CNT_W-1 to 0 with no flag.
- Back-to-back commits to the same dr on consecutive cycles: the last one wins. A read in the following cycle sees the latest value.
- Reset asserted mid-commit: the commit is discarded and all state goes to reset values immediately. The first edge after release behaves as normal.
- No X propagation: an out-of-range address is impossible because NUM_REGS is a power of 2.

Test Plan:
- Reset check: hold rst low, toggle inputs, release. Required: d1=d2=0, psr=000, commit_cnt=0. Reading R0..R7 gives 0.
- Source select: commit to R3 each cycle with w_control_in 0..3 and aluout=16'h0011, memout=16'h8000, pcout=16'h0000, npc=16'h3001.
  - Required wb_data sequence: 0011, 8000, 0000, 3001.
  - Required psr sequence: 001, 100, 010, then held at 010 (CC_ON_LINK=0).
  - Rerun with CC_ON_LINK=1: the last psr must be 001.
- Bypass: commit aluout=16'hBEEF to dr=5 while sr1=5, sr2=5 in the same cycle. Required: next cycle d1=d2=BEEF.
  - Repeat with enable_writeback=0: d1 and d2 must show the old R5 value.
- Back-to-back same dr: write 16'h1234 then 16'h5678 to R2 on consecutive edges, then read sr1=2. Required: d1=5678, commit_cnt +2, wb_valid high for 2 cycles.
- Counter wrap: with CNT_W=4, perform 17 commits. Required: commit_cnt=1.
- Async reset mid-write: drop rst between edges during a commit stream. Required: outputs clear before the next edge; the interrupted write is absent from R[dr].
  - Also rerun with DATA_W=32, NUM_REGS=16 (AW=4): repeat the bypass and psr checks, using N on bit 31.
